// File: rtl/cymometer_sched_if.sv
// Scheduler-side bundle: channel enables, cymometer core handshake and result readback.
// The scheduler uses the slave modport; whatever drives the inputs uses master.
interface cymometer_sched_if;
    logic [3:0]  ch_en;
    logic        meas_done;
    logic [19:0] meas_data;
    logic [1:0]  rd_addr;
    logic [1:0]  ch_sel;
    logic        meas_start;
    logic        busy;
    logic [19:0] rd_data;
    logic [3:0]  err;
    logic        upd;
    logic [1:0]  upd_ch;

    modport slave (
        input  ch_en, meas_done, meas_data, rd_addr,
        output ch_sel, meas_start, busy, rd_data, err, upd, upd_ch
    );

    modport master (
        output ch_en, meas_done, meas_data, rd_addr,
        input  ch_sel, meas_start, busy, rd_data, err, upd, upd_ch
    );
endinterface

// File: rtl/cymometer_sched.sv
// Round-robin scheduler sharing one frequency counter across up to four input clocks.
// Selects a channel, lets the mux settle, runs one measurement and stores result or timeout.
module cymometer_sched #(
    parameter logic [2:0]  CH_NUM     = 3'd4,
    parameter logic [7:0]  SETTLE_CYC = 8'd16,
    parameter logic [26:0] TIMEOUT    = 27'd100000000
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_n_i,
    cymometer_sched_if.slave  bus
);
    localparam int unsigned NCH     = int'(CH_NUM);
    localparam logic [3:0]  CH_MASK = 4'((5'd1 << CH_NUM) - 5'd1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_START, S_WAIT, S_STORE, S_NEXT
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  ch_sel_q, ch_sel_d;
    logic [7:0]  settle_q, settle_d;
    logic [26:0] tmo_q, tmo_d;
    logic [19:0] cap_q, cap_d;
    logic        ok_q, ok_d;
    logic [3:0]  err_q;
    logic [19:0] result_q [NCH];
    logic [19:0] rd_q;

    logic [3:0]  en_v;
    logic [1:0]  first_ch;
    logic [1:0]  next_ch;
    logic [2:0]  cand;

    // Descending loops let the lowest index / nearest circular successor win.
    always_comb begin : ch_search
        en_v     = bus.ch_en & CH_MASK;
        first_ch = '0;
        next_ch  = ch_sel_q;
        cand     = '0;
        for (int unsigned i = 4; i > 0; i--) begin
            if (en_v[2'(i - 1)]) first_ch = 2'(i - 1);
        end
        for (int unsigned k = 4; k > 0; k--) begin
            if (k <= NCH) begin
                cand = {1'b0, ch_sel_q} + 3'(k);
                if (cand >= CH_NUM) cand = cand - CH_NUM;
                if (en_v[cand[1:0]]) next_ch = cand[1:0];
            end
        end
    end

    always_comb begin : fsm_next
        state_d  = state_q;
        ch_sel_d = ch_sel_q;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        cap_d    = cap_q;
        ok_d     = ok_q;
        case (state_q)
            S_IDLE: begin
                if (|en_v) begin
                    ch_sel_d = first_ch;
                    settle_d = '0;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if ({1'b0, settle_q} + 9'd1 >= {1'b0, SETTLE_CYC}) state_d = S_START;
                else settle_d = settle_q + 8'd1;
            end
            S_START: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.meas_done) begin
                    cap_d   = bus.meas_data;
                    ok_d    = 1'b1;
                    state_d = S_STORE;
                end else if (tmo_q >= TIMEOUT - 27'd1) begin
                    ok_d    = 1'b0;
                    state_d = S_STORE;
                end else if (tmo_q != '1) begin
                    tmo_d = tmo_q + 27'd1;
                end
            end
            S_STORE: state_d = S_NEXT;
            S_NEXT: begin
                if (!(|en_v)) begin
                    state_d = S_IDLE;
                end else if (next_ch == ch_sel_q) begin
                    state_d = S_START;
                end else begin
                    ch_sel_d = next_ch;
                    settle_d = '0;
                    state_d  = S_SETTLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            state_q  <= S_IDLE;
            ch_sel_q <= '0;
            settle_q <= '0;
            tmo_q    <= '0;
            cap_q    <= '0;
            ok_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_sel_q <= ch_sel_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            cap_q    <= cap_d;
            ok_q     <= ok_d;
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
        if (!sys_rst_n_i) begin
            err_q <= '0;
            rd_q  <= '0;
            for (int unsigned i = 0; i < NCH; i++) result_q[i] <= '0;
        end else begin
            if (state_q == S_STORE) begin
                result_q[ch_sel_q] <= ok_q ? cap_q : '0;
                err_q[ch_sel_q]    <= !ok_q;
            end
            rd_q <= ({1'b0, bus.rd_addr} < CH_NUM) ? result_q[bus.rd_addr] : '0;
        end
    end

    always_comb begin : outputs
        bus.ch_sel     = ch_sel_q;
        bus.meas_start = (state_q == S_START);
        bus.busy       = (state_q != S_IDLE);
        bus.upd        = (state_q == S_STORE);
        bus.upd_ch     = ch_sel_q;
        bus.err        = err_q;
        bus.rd_data    = rd_q;
    end
endmodule
